// File: rtl/tone_sequencer.sv
// Melody sequencer driving the one-hot tone bus and volume of the PWM tone generator.
// Optional song looping is enabled by defining TONE_SEQ_LOOP_EN.
module tone_sequencer #(
   parameter int unsigned TICK_DIV  = 100000,
   parameter int unsigned GAP_TICKS = 20,
   parameter int unsigned SONG_LEN  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic        loop_i,
   input  logic [7:0]  vol_in_i,
   input  logic        wr_en_i,
   input  logic [3:0]  wr_addr_i,
   input  logic [12:0] wr_data_i,
   output logic [15:0] tone_o,
   output logic [7:0]  volume_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [3:0]  note_idx_o
);

   localparam int unsigned TONE_W  = 16;
   localparam int unsigned VOL_W   = 8;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned ENTRIES = 16;
   localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned REM_W   = (GAP_TICKS > 255) ? $clog2(GAP_TICKS + 1) : 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_NOTE  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   typedef struct packed {
      logic       rest;
      logic [3:0] sel;
      logic [7:0] dur;
   } entry_t;

   entry_t              tbl_q [ENTRIES];
   entry_t              entry_c;
   logic [1:0]          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [TONE_W-1:0]   tone_q, tone_d;
   logic [VOL_W-1:0]    vol_q, vol_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                tick_c, adv_c, end_c;

`ifndef TONE_SEQ_LOOP_EN
   logic unused_loop_c;
   assign unused_loop_c = loop_i;
`endif

   // Note table; writable in any state, contents only observed at FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) tbl_q[i] <= '0;
      end else if (wr_en_i) begin
         tbl_q[wr_addr_i] <= entry_t'(wr_data_i);
      end
   end

   assign entry_c = tbl_q[idx_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         pre_q   <= '0;
         rem_q   <= '0;
         tone_q  <= '0;
         vol_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pre_q   <= pre_d;
         rem_q   <= rem_d;
         tone_q  <= tone_d;
         vol_q   <= vol_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state and registered output values; rem_q counts ticks left in the segment
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pre_d   = pre_q;
      rem_d   = rem_q;
      tone_d  = tone_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      adv_c   = 1'b0;
      end_c   = 1'b0;
      tick_c  = (pre_q == PRE_W'(TICK_DIV - 1));

      case (state_q)
         S_IDLE: begin
            if (start_i && !stop_i) begin
               state_d = S_FETCH;
               idx_d   = '0;
               pre_d   = '0;
               busy_d  = 1'b1;
               tone_d  = '0;
            end
         end
         S_FETCH: begin
            if (entry_c.dur == '0) begin
               end_c = 1'b1;
            end else begin
               state_d = S_NOTE;
               rem_d   = REM_W'(entry_c.dur);
               pre_d   = '0;
               tone_d  = entry_c.rest ? '0 : (TONE_W'(1) << entry_c.sel);
            end
         end
         S_NOTE: begin
            if (tick_c) begin
               pre_d = '0;
               if (rem_q == REM_W'(1)) begin
                  if (GAP_TICKS == 0) begin
                     adv_c = 1'b1;
                  end else begin
                     state_d = S_GAP;
                     rem_d   = REM_W'(GAP_TICKS);
                     tone_d  = '0;
                  end
               end else begin
                  rem_d = rem_q - REM_W'(1);
               end
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end
         S_GAP: begin
            if (tick_c) begin
               pre_d = '0;
               if (rem_q == REM_W'(1)) adv_c = 1'b1;
               else                    rem_d = rem_q - REM_W'(1);
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (adv_c) begin
         if (idx_q == IDX_W'(SONG_LEN - 1)) begin
            end_c = 1'b1;
         end else begin
            state_d = S_FETCH;
            idx_d   = idx_q + IDX_W'(1);
            tone_d  = '0;
         end
      end

      if (end_c) begin
         tone_d = '0;
`ifdef TONE_SEQ_LOOP_EN
         if (loop_i) begin
            state_d = S_FETCH;
            idx_d   = '0;
         end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
`else
         state_d = S_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b1;
`endif
      end

      // Abort overrides everything, including a completion on the same edge
      if (stop_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         tone_d  = '0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end

      vol_d = (tone_d != '0) ? vol_in_i : '0;
   end

   assign tone_o     = tone_q;
   assign volume_o   = vol_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign note_idx_o = idx_q;

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a programmable melody on the one-hot tone bus that drives the PWM tone generator. Software or top-level logic loads a 16-entry note table, pulses `start`, and the block steps through the entries, timing each note and inter-note gap with a prescaled tick. It also gates the volume. It is the only writer of the tone generator's `tone[15:0]` and `volume[7:0]` inputs.

## Interface
- `TICK_DIV`, 100000: clk cycles per duration tick (1 ms at 100 MHz); legal range ≥1.
- `GAP_TICKS`, 20: silent ticks inserted after every entry; 0 means no gap.
- `SONG_LEN`, 16: number of table entries; legal range 1..16.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle start request; sampled only in IDLE.
- `stop`  in  1  abort request; sampled in every state.
- `loop`  in  1  repeat the song at end (see Configuration).
- `vol_in`  in  8  volume applied while a tone sounds.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  4  table entry index.
- `wr_data`  in  13  entry format {rest, sel[3:0], dur[7:0]}.
- `tone`  out  16  one-hot tone select (`1 << sel`), or 0.
- `volume`  out  8  `vol_in` while tone≠0, else 0.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at normal song completion.
- `note_idx`  out  4  index of the entry being played.

## Operation
- Table: 16×13 registers, all cleared to 0 on reset.
  - Writes are accepted in any state.
  - A write to the entry currently sounding does not change it, because the entry is latched at FETCH.
- FSM states are IDLE, FETCH, NOTE, GAP.
- IDLE → FETCH on `start`. `note_idx` is set to 0 and the prescaler is cleared.
- FETCH reads `table[note_idx]`:
  - If `dur`=0 (end marker): `done` pulses and the FSM goes to IDLE.
  - Otherwise: `rest`, `sel` and `dur` are latched and the FSM goes to NOTE.
- NOTE:
  - `tone` = `rest` ? 0 : `1<<sel`.
  - Lasts exactly `dur` ticks.
  - Then → GAP, or → ADVANCE directly if `GAP_TICKS`=0.
- GAP: `tone`=0 for `GAP_TICKS` ticks, then ADVANCE.
- ADVANCE is not a state; it is the transition action out of NOTE/GAP:
  - If `note_idx`=`SONG_LEN-1`, it is the end of the song: `done` pulses and the FSM goes to IDLE.
  - Otherwise `note_idx`+1 and the FSM goes to FETCH.
- Prescaler:
  - Counts 0..`TICK_DIV-1` and is cleared when entering NOTE and when entering GAP.
  - Each segment length is an exact multiple of `TICK_DIV` cycles.
- `stop` from any non-IDLE state:
  - Next state is IDLE; `tone`, `volume` and `busy` go to 0 on the next edge.
  - `done` is not pulsed.
- `start` and `stop` in the same cycle: `stop` wins and the FSM stays in IDLE.
- `start` while busy is ignored.
- `vol_in` is sampled every cycle, so volume changes take effect mid-note.

## Timing
- All outputs are registered. Reset values: `tone`=0, `volume`=0, `busy`=0, `done`=0, `note_idx`=0. State after reset is IDLE.
- `start` high at edge k:
  - `busy`=1 after edge k.
  - FETCH occupies cycle k..k+1.
  - `tone` is valid after edge k+1.
- Segment lengths:
  - NOTE is held for exactly `dur×TICK_DIV` cycles.
  - GAP is held for exactly `GAP_TICKS×TICK_DIV` cycles.
  - Each subsequent entry adds one FETCH cycle with `tone`=0.
- End of song: the `done` pulse and `busy`=0 appear on the same edge.
- Reset mid-song: all outputs return to their reset values immediately (asynchronous). The table is cleared.

## Configuration
- `TONE_SEQ_LOOP_EN` defined:
  - At end of song (end marker or last entry), if `loop`=1 the FSM goes to FETCH with `note_idx`=0 and `done` is not pulsed.
  - If `loop`=0, the end behaviour is normal.
- `TONE_SEQ_LOOP_EN` undefined: the `loop` port exists but is ignored, and the song always ends with `done`.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `GAP_TICKS`=1, `SONG_LEN`=16.

- Reset: assert `rst_n`=0 mid-NOTE → all outputs 0 immediately; after release, a table readback via playback shows end marker at entry 0.
- Basic song: entries 0={0,0,2}, 1={0,5,1}, 2={0,0,0}; `start` →
  - after 1 FETCH cycle, `tone`=0x0001 for 8 cycles, then 0 for 4+1 cycles;
  - then `tone`=0x0020 for 4 cycles, then 0 for 4+1 cycles;
  - then a `done` pulse, with `busy` low on the same edge.
- Rest and volume: entry 0={1,3,2}, `vol_in`=0x80 → `tone`=0 and `volume`=0 for 8 cycles while `busy`=1; entry {0,3,2} → `volume`=0x80 while `tone`=0x0008.
- Stop and collisions:
  - `stop` on the 3rd NOTE cycle → `tone`=0 and `busy`=0 next cycle, no `done`.
  - `start`+`stop` together → no activity.
  - `start` while busy → ignored.
- Empty and full table:
  - entry 0 `dur`=0 → `done` exactly 2 cycles after `start`.
  - all 16 entries `dur`=1 → `note_idx` goes 0..15, then `done`.
- Loop (macro defined), basic song, `loop`=1 → after entry 1 the gap, FETCH returns to index 0 and `tone`=0x0001 reappears with no `done`; drop `loop` → `done` at the next end.
